// File: rtl/mul_seq_if.sv
// Request/response bundle between the execute stage and the sequential multiplier.
interface mul_seq_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start_i;
    logic [3:0]        ALUCtrl_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic              stall_o;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] result_o;

    modport master (
        output start_i, ALUCtrl_i, src1_i, src2_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, ALUCtrl_i, src1_i, src2_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add multiplier controller: one multiplier bit per cycle, low-half
// result, stalls the front of the pipeline while the multiply is in flight.
module mul_seq_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mul_seq_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam logic [3:0]  MUL_OP = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_sum;
    logic [DATA_W-1:0] result;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              last;
    logic              stall;

    assign accept  = (state == IDLE) && bus.start_i && (bus.ALUCtrl_i == MUL_OP);
    assign last    = (cnt == CNT_W'(DATA_W - 1));
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the combinational stall request
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    stall     = 1'b1;
                end
            end
            RUN: begin
                stall = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst_i) begin
            stall = 1'b0;
        end
    end

    // Operand shifting, accumulation and result capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= bus.src1_i;
                        mplier <= bus.src2_i;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        result <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.stall_o  = stall;
    assign bus.busy_o   = (state != IDLE);
    assign bus.done_o   = (state == DONE);
    assign bus.result_o = result;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: driver queues expected products, monitor
// pops one per done pulse.
module tb_mul_seq_ctrl;
    localparam int unsigned DATA_W = 32;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    mul_seq_if #(.DATA_W(DATA_W)) bus();

    mul_seq_ctrl #(.DATA_W(DATA_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int                tests = 0;
    int                fails = 0;
    int                n_req = 0;
    int                n_done = 0;
    logic              prev_done = 1'b0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] p;
        p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        return p[DATA_W-1:0];
    endfunction

    // Monitor: every done pulse retires exactly one queued expectation
    always @(negedge clk_i) begin
        if (bus.done_o) begin
            check("done_single_pulse", 64'(prev_done), 64'd0);
            if (exp_q.size() == 0) begin
                check("done_without_request", 64'd1, 64'd0);
            end else begin
                check("result", 64'(bus.result_o), 64'(exp_q.pop_front()));
            end
            n_done++;
        end
        prev_done = bus.done_o;
    end

    // One multiply from IDLE; optionally inject a busy start or a reset at RUN cycle k
    task automatic run_mult(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input int inject_at, input int rst_at);
        int   k;
        int   stalls;
        logic aborted;
        k       = 0;
        stalls  = 0;
        aborted = 1'b0;
        @(negedge clk_i);
        bus.start_i   = 1'b1;
        bus.ALUCtrl_i = 4'd3;
        bus.src1_i    = a;
        bus.src2_i    = b;
        #1;
        check("stall_on_accept", 64'(bus.stall_o), 64'd1);
        if (bus.stall_o) stalls++;
        exp_q.push_back(model(a, b));
        n_req++;
        @(posedge clk_i);
        #1;
        bus.start_i   = 1'b0;
        bus.ALUCtrl_i = 4'($urandom_range(0, 15));
        bus.src1_i    = DATA_W'($urandom);
        bus.src2_i    = DATA_W'($urandom);
        while (k < 100) begin
            @(negedge clk_i);
            if (bus.done_o) break;
            if (bus.stall_o) stalls++;
            if (k == inject_at) begin
                bus.start_i   = 1'b1;
                bus.ALUCtrl_i = 4'd3;
                bus.src1_i    = DATA_W'(3);
                bus.src2_i    = DATA_W'(3);
            end
            if (k == rst_at) begin
                rst_i = 1'b1;
                void'(exp_q.pop_back());
                n_req--;
            end
            @(posedge clk_i);
            #1;
            bus.start_i = 1'b0;
            if (rst_i) begin
                rst_i   = 1'b0;
                aborted = 1'b1;
                break;
            end
            k++;
        end
        if (aborted) begin
            @(negedge clk_i);
            check("reset_busy", 64'(bus.busy_o), 64'd0);
            check("reset_done", 64'(bus.done_o), 64'd0);
            check("reset_result", 64'(bus.result_o), 64'd0);
            repeat (40) @(negedge clk_i);
            check("reset_idle_after", 64'(bus.busy_o), 64'd0);
        end else begin
            if (k >= 100) check("done_timeout", 64'(k), 64'(DATA_W));
            check("latency", 64'(k), 64'(DATA_W));
            check("stall_cycles", 64'(stalls), 64'(DATA_W + 1));
            check("stall_in_done", 64'(bus.stall_o), 64'd0);
            @(negedge clk_i);
            check("idle_after_done", 64'(bus.busy_o), 64'd0);
        end
    endtask

    // Non-mult code must be invisible
    task automatic ignore_code(input logic [3:0] code);
        logic [DATA_W-1:0] prev;
        @(negedge clk_i);
        prev          = bus.result_o;
        bus.start_i   = 1'b1;
        bus.ALUCtrl_i = code;
        bus.src1_i    = DATA_W'($urandom);
        bus.src2_i    = DATA_W'($urandom);
        #1;
        check("nonmult_stall", 64'(bus.stall_o), 64'd0);
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check("nonmult_busy", 64'(bus.busy_o), 64'd0);
            check("nonmult_result", 64'(bus.result_o), 64'(prev));
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        bus.start_i   = 1'b1;
        bus.ALUCtrl_i = 4'd3;
        bus.src1_i    = DATA_W'(7);
        bus.src2_i    = DATA_W'(6);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_result", 64'(bus.result_o), 64'd0);
        rst_i       = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk_i);
        check("rst_start_dropped", 64'(bus.busy_o), 64'd0);

        run_mult(DATA_W'(7), DATA_W'(6), -1, -1);
        run_mult(32'hFFFF_FFFF, DATA_W'(2), -1, -1);
        run_mult(32'h8000_0000, DATA_W'(2), -1, -1);
        ignore_code(4'd2);
        ignore_code(4'd6);
        run_mult(DATA_W'(5), DATA_W'(5), 10, -1);
        run_mult(DATA_W'(3), DATA_W'(3), -1, -1);
        run_mult(DATA_W'(32'h1234), DATA_W'(32'h10), -1, 16);
        run_mult(DATA_W'(32'h1234), DATA_W'(32'h10), -1, -1);
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_mult(DATA_W'(0), 32'hDEAD_BEEF, -1, -1);

        for (int i = 0; i < 1000; i++) begin
            run_mult(DATA_W'($urandom), DATA_W'($urandom), -1, -1);
        end

        repeat (5) @(negedge clk_i);
        check("done_count", 64'(n_done), 64'(n_req));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
